// File: rtl/cpu_state_sequencer.sv
// Main control FSM of the prototype processor: produces the 4-bit STATE code for the
// state decoders, plus retire pulse/counter, halt handling and RAM wait timeout.
module cpu_state_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CPU_EN,
    input  logic [1:0]       OPCLASS,
    input  logic             BR_TAKEN,
    input  logic             MEM_READY,
    input  logic             HALT_REQ,
    input  logic             RESUME,
    output logic [3:0]       STATE,
    output logic             INSTR_DONE,
    output logic             HALTED,
    output logic             MEM_TIMEOUT,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    // Encoding is shared with the downstream decoders and must not change.
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_PC_INC   = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_PC_LOAD  = 4'd3;
    localparam logic [3:0] ST_MEM_RD   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_MEM_WAIT = 4'd6;
    localparam logic [3:0] ST_MEM_DONE = 4'd7;
    localparam logic [3:0] ST_EXEC     = 4'd8;
    localparam logic [3:0] ST_HALT     = 4'd15;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             instr_done_q, instr_done_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             end_st_hit_s;
    logic [3:0]       end_st_s;
    logic             retire_s;
    logic             wait_expire_s;

    assign end_st_s      = halt_pend_q ? ST_HALT : ST_FETCH;
    assign wait_expire_s = (state_q == ST_MEM_WAIT) && !MEM_READY && (wait_cnt_q == TO_LAST);
    assign end_st_hit_s  = (state_q == ST_DECODE) && (OPCLASS == 2'b11) && !BR_TAKEN;

    // State and status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_FETCH;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            instr_done_q  <= 1'b0;
            halted_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_pend_q   <= halt_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            instr_done_q  <= instr_done_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                // A pending or fresh halt request is honoured here since FETCH is a boundary.
                if (halt_pend_q || HALT_REQ) begin
                    state_d = ST_HALT;
                end else if (CPU_EN) begin
                    state_d = ST_PC_INC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PC_INC: state_d = ST_DECODE;
            ST_DECODE: begin
                case (OPCLASS)
                    2'b00:   state_d = ST_EXEC;
                    2'b01:   state_d = ST_MEM_RD;
                    2'b10:   state_d = ST_MEM_WR;
                    default: begin
                        if (BR_TAKEN) begin
                            state_d = ST_PC_LOAD;
                        end else begin
                            state_d = end_st_s;
                        end
                    end
                endcase
            end
            ST_PC_LOAD:  state_d = end_st_s;
            ST_EXEC:     state_d = end_st_s;
            ST_MEM_DONE: state_d = end_st_s;
            ST_MEM_RD:   state_d = ST_MEM_WAIT;
            ST_MEM_WR:   state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (MEM_READY) begin
                    state_d = ST_MEM_DONE;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_HALT: begin
                if (RESUME && !HALT_REQ) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Retire detection.
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            ST_PC_LOAD:  retire_s = 1'b1;
            ST_EXEC:     retire_s = 1'b1;
            ST_MEM_DONE: retire_s = 1'b1;
            ST_DECODE:   retire_s = end_st_hit_s;
            default:     retire_s = 1'b0;
        endcase
    end

    // Output and bookkeeping logic derived from the current transition.
    always_comb begin
        instr_done_d  = retire_s;
        halted_d      = (state_d == ST_HALT);
        if (retire_s) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end else begin
            instr_count_d = instr_count_q;
        end

        case (state_q)
            ST_MEM_RD:   wait_cnt_d = '0;
            ST_MEM_WR:   wait_cnt_d = '0;
            ST_MEM_WAIT: begin
                if (!MEM_READY && (wait_cnt_q != TO_LAST)) begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default:     wait_cnt_d = wait_cnt_q;
        endcase

        if (wait_expire_s) begin
            mem_timeout_d = 1'b1;
        end else if ((state_q == ST_HALT) && (state_d == ST_FETCH)) begin
            mem_timeout_d = 1'b0;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end

        // Entering HALT consumes the request; requests seen while halted are ignored.
        if ((state_q != ST_HALT) && (state_d == ST_HALT)) begin
            halt_pend_d = 1'b0;
        end else if ((state_q != ST_HALT) && HALT_REQ) begin
            halt_pend_d = 1'b1;
        end else if ((state_q == ST_HALT) && (state_d == ST_FETCH)) begin
            halt_pend_d = 1'b0;
        end else begin
            halt_pend_d = halt_pend_q;
        end
    end

    assign STATE       = state_q;
    assign INSTR_DONE  = instr_done_q;
    assign HALTED      = halted_q;
    assign MEM_TIMEOUT = mem_timeout_q;
    assign INSTR_COUNT = instr_count_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench for cpu_state_sequencer; a narrow-counter twin instance covers count wrap.
module tb_cpu_state_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CPU_EN = 1'b0;
    logic [1:0]  OPCLASS = 2'b00;
    logic        BR_TAKEN = 1'b0;
    logic        MEM_READY = 1'b0;
    logic        HALT_REQ = 1'b0;
    logic        RESUME = 1'b0;
    logic [3:0]  STATE;
    logic        INSTR_DONE, HALTED, MEM_TIMEOUT;
    logic [15:0] INSTR_COUNT;
    logic [3:0]  w_state;
    logic        w_done, w_halted, w_timeout;
    logic [2:0]  w_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;

    cpu_state_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .CPU_EN(CPU_EN), .OPCLASS(OPCLASS), .BR_TAKEN(BR_TAKEN),
        .MEM_READY(MEM_READY), .HALT_REQ(HALT_REQ), .RESUME(RESUME), .STATE(STATE),
        .INSTR_DONE(INSTR_DONE), .HALTED(HALTED), .MEM_TIMEOUT(MEM_TIMEOUT),
        .INSTR_COUNT(INSTR_COUNT)
    );

    cpu_state_sequencer #(.CNT_W(3)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .CPU_EN(CPU_EN), .OPCLASS(OPCLASS), .BR_TAKEN(BR_TAKEN),
        .MEM_READY(MEM_READY), .HALT_REQ(HALT_REQ), .RESUME(RESUME), .STATE(w_state),
        .INSTR_DONE(w_done), .HALTED(w_halted), .MEM_TIMEOUT(w_timeout),
        .INSTR_COUNT(w_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_instr(input logic [1:0] op, input logic br);
        OPCLASS  = op;
        BR_TAKEN = br;
        CPU_EN   = 1'b1;
        tick();
        CPU_EN   = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #3;
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", STATE); end
        #19;
        RST_N = 1'b1;
        checks++; if (INSTR_DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", INSTR_DONE); end
        checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", HALTED); end
        checks++; if (MEM_TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b expected 0", MEM_TIMEOUT); end
        checks++; if (INSTR_COUNT !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", INSTR_COUNT); end
    endtask

    task automatic test_alu();
        logic [3:0] seq [3] = '{4'd2, 4'd8, 4'd0};
        start_instr(2'b00, 1'b0);
        checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL alu_pcinc got %0d expected 1", STATE); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (STATE !== seq[i]) begin errors++; $display("FAIL alu_seq%0d got %0d expected %0d", i, STATE, seq[i]); end
        end
        exp_count++;
        checks++; if (INSTR_DONE !== 1'b1) begin errors++; $display("FAIL alu_done got %b expected 1", INSTR_DONE); end
        checks++; if (INSTR_COUNT !== exp_count) begin errors++; $display("FAIL alu_count got %0d expected %0d", INSTR_COUNT, exp_count); end
        tick();
        checks++; if (STATE !== 4'd0 || INSTR_DONE !== 1'b0) begin errors++; $display("FAIL alu_idle got state %0d done %b expected 0 0", STATE, INSTR_DONE); end
    endtask

    task automatic test_branch();
        logic [3:0] seq [3] = '{4'd2, 4'd3, 4'd0};
        start_instr(2'b11, 1'b1);
        checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL brt_pcinc got %0d expected 1", STATE); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (STATE !== seq[i]) begin errors++; $display("FAIL brt_seq%0d got %0d expected %0d", i, STATE, seq[i]); end
        end
        exp_count++;
        checks++; if (INSTR_DONE !== 1'b1 || INSTR_COUNT !== exp_count) begin errors++; $display("FAIL brt_retire got done %b count %0d expected 1 %0d", INSTR_DONE, INSTR_COUNT, exp_count); end
        start_instr(2'b11, 1'b0);
        tick();
        checks++; if (STATE !== 4'd2) begin errors++; $display("FAIL brn_decode got %0d expected 2", STATE); end
        tick();
        exp_count++;
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL brn_fetch got %0d expected 0", STATE); end
        checks++; if (INSTR_DONE !== 1'b1 || INSTR_COUNT !== exp_count) begin errors++; $display("FAIL brn_retire got done %b count %0d expected 1 %0d", INSTR_DONE, INSTR_COUNT, exp_count); end
    endtask

    task automatic test_load();
        logic [3:0] seq [5] = '{4'd2, 4'd4, 4'd6, 4'd6, 4'd6};
        start_instr(2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (STATE !== seq[i]) begin errors++; $display("FAIL load_seq%0d got %0d expected %0d", i, STATE, seq[i]); end
        end
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        checks++; if (STATE !== 4'd7) begin errors++; $display("FAIL load_done_state got %0d expected 7", STATE); end
        tick();
        exp_count++;
        checks++; if (STATE !== 4'd0 || INSTR_DONE !== 1'b1) begin errors++; $display("FAIL load_end got state %0d done %b expected 0 1", STATE, INSTR_DONE); end
        checks++; if (INSTR_COUNT !== exp_count || MEM_TIMEOUT !== 1'b0) begin errors++; $display("FAIL load_status got count %0d to %b expected %0d 0", INSTR_COUNT, MEM_TIMEOUT, exp_count); end
    endtask

    task automatic test_timeout();
        start_instr(2'b10, 1'b0);
        tick();
        tick();
        checks++; if (STATE !== 4'd5) begin errors++; $display("FAIL to_memwr got %0d expected 5", STATE); end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++; if (STATE !== 4'd6) begin errors++; $display("FAIL to_wait%0d got %0d expected 6", i, STATE); end
        end
        tick();
        checks++; if (STATE !== 4'd15 || HALTED !== 1'b1) begin errors++; $display("FAIL to_halt got state %0d halted %b expected 15 1", STATE, HALTED); end
        checks++; if (MEM_TIMEOUT !== 1'b1) begin errors++; $display("FAIL to_flag got %b expected 1", MEM_TIMEOUT); end
        checks++; if (INSTR_COUNT !== exp_count || INSTR_DONE !== 1'b0) begin errors++; $display("FAIL to_noretire got count %0d done %b expected %0d 0", INSTR_COUNT, INSTR_DONE, exp_count); end
        tick();
        checks++; if (STATE !== 4'd15 || MEM_TIMEOUT !== 1'b1) begin errors++; $display("FAIL to_sticky got state %0d to %b expected 15 1", STATE, MEM_TIMEOUT); end
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        checks++; if (STATE !== 4'd0 || MEM_TIMEOUT !== 1'b0 || HALTED !== 1'b0) begin errors++; $display("FAIL to_resume got state %0d to %b halted %b expected 0 0 0", STATE, MEM_TIMEOUT, HALTED); end
    endtask

    task automatic test_halt_req();
        start_instr(2'b01, 1'b0);
        tick();
        tick();
        tick();
        checks++; if (STATE !== 4'd6) begin errors++; $display("FAIL hr_wait got %0d expected 6", STATE); end
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        checks++; if (STATE !== 4'd7) begin errors++; $display("FAIL hr_complete got %0d expected 7", STATE); end
        tick();
        exp_count++;
        checks++; if (STATE !== 4'd15 || HALTED !== 1'b1) begin errors++; $display("FAIL hr_halt got state %0d halted %b expected 15 1", STATE, HALTED); end
        checks++; if (INSTR_DONE !== 1'b1 || INSTR_COUNT !== exp_count) begin errors++; $display("FAIL hr_retire got done %b count %0d expected 1 %0d", INSTR_DONE, INSTR_COUNT, exp_count); end
        HALT_REQ = 1'b1;
        RESUME = 1'b1;
        tick();
        checks++; if (STATE !== 4'd15) begin errors++; $display("FAIL hr_both got %0d expected 15", STATE); end
        HALT_REQ = 1'b0;
        tick();
        RESUME = 1'b0;
        checks++; if (STATE !== 4'd0 || HALTED !== 1'b0) begin errors++; $display("FAIL hr_resume got state %0d halted %b expected 0 0", STATE, HALTED); end
        tick();
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL hr_no_rehalt got %0d expected 0", STATE); end
    endtask

    task automatic test_idle_halt();
        CPU_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL idle%0d got %0d expected 0", i, STATE); end
        end
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        checks++; if (STATE !== 4'd15 || HALTED !== 1'b1) begin errors++; $display("FAIL idle_halt got state %0d halted %b expected 15 1", STATE, HALTED); end
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL idle_resume got %0d expected 0", STATE); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [8] = '{4'd1, 4'd2, 4'd8, 4'd0, 4'd1, 4'd2, 4'd8, 4'd0};
        OPCLASS = 2'b00;
        CPU_EN  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) CPU_EN = 1'b0;
            checks++; if (STATE !== seq[i]) begin errors++; $display("FAIL b2b_seq%0d got %0d expected %0d", i, STATE, seq[i]); end
            if (seq[i] == 4'd0) begin
                exp_count++;
                checks++; if (INSTR_DONE !== 1'b1 || INSTR_COUNT !== exp_count) begin errors++; $display("FAIL b2b_retire%0d got done %b count %0d expected 1 %0d", i, INSTR_DONE, INSTR_COUNT, exp_count); end
            end
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            start_instr(2'b11, 1'b0);
            tick();
            tick();
            exp_count++;
            checks++; if (INSTR_COUNT !== exp_count) begin errors++; $display("FAIL wrap_main%0d got %0d expected %0d", k, INSTR_COUNT, exp_count); end
            checks++; if (w_count !== exp_count[2:0] || w_done !== 1'b1) begin errors++; $display("FAIL wrap_narrow%0d got count %0d done %b expected %0d 1", k, w_count, w_done, exp_count[2:0]); end
        end
        checks++; if (w_state !== STATE || w_halted !== HALTED || w_timeout !== MEM_TIMEOUT) begin errors++; $display("FAIL wrap_twin got state %0d expected %0d", w_state, STATE); end
    endtask

    task automatic test_reset_mid();
        start_instr(2'b01, 1'b0);
        tick();
        tick();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL rst_mid_state got %0d expected 0", STATE); end
        checks++; if (INSTR_COUNT !== 16'd0 || INSTR_DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_count got count %0d done %b expected 0 0", INSTR_COUNT, INSTR_DONE); end
        exp_count = 16'd0;
        #3;
        RST_N = 1'b1;
        tick();
        checks++; if (STATE !== 4'd0 || INSTR_COUNT !== exp_count) begin errors++; $display("FAIL rst_mid_after got state %0d count %0d expected 0 0", STATE, INSTR_COUNT); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_timeout();
        test_halt_req();
        test_idle_halt();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
